// File: rtl/wb_slot_scheduler_pkg.sv
// Shared types and reset defaults for the Wishbone / CPU slot scheduler.
package wb_slot_scheduler_pkg;

    localparam int SLOT_COUNT = 8;

    typedef enum logic [1:0] {
        OWNER_IDLE  = 2'd0,
        OWNER_VIDEO = 2'd1,
        OWNER_CPU   = 2'd2,
        OWNER_SPI   = 2'd3
    } owner_t;

    // Two bits per slot, slot 0 in the LSBs: {S,S,C,C,V,V,V,V} from slot 7 down to slot 0.
    localparam logic [2*SLOT_COUNT-1:0] DEFAULT_SLOT_TABLE = 16'hFA55;

    function automatic owner_t default_owner(input int idx);
        if (idx < SLOT_COUNT) begin
            return owner_t'(DEFAULT_SLOT_TABLE[2*idx +: 2]);
        end
        return OWNER_IDLE;
    endfunction

endpackage

// File: rtl/wb_slot_scheduler_slot_table.sv
// Slot ownership register file: one write port, one combinational read port.
module wb_slot_scheduler_slot_table
    import wb_slot_scheduler_pkg::*;
#(
    parameter int SLOT_BITS = 3
) (
    input  logic                 clk_sys,
    input  logic                 rst_b,
    input  logic                 we,
    input  logic [SLOT_BITS-1:0] wr_slot,
    input  logic [1:0]           wr_owner,
    input  logic [SLOT_BITS-1:0] rd_slot,
    output logic [1:0]           rd_owner
);

    localparam int DEPTH = 2 ** SLOT_BITS;

    logic [1:0] table_q [DEPTH];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= default_owner(i);
            end
        end else if (we) begin
            table_q[wr_slot] <= wr_owner;
        end
    end

    // Read sees the pre-write contents, so a write landing on the advance edge is not latched.
    assign rd_owner = table_q[rd_slot];

endmodule

// File: rtl/wb_slot_scheduler.sv
// Slot-table driven scheduler for the shared Wishbone bus and the CPU memory window.
module wb_slot_scheduler
    import wb_slot_scheduler_pkg::*;
#(
    parameter int SLOT_BITS     = 3,
    parameter int OVR_CNT_WIDTH = 8
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_ni,
    input  logic                     clk8_en_i,
    input  logic                     video_cycle_i,
    input  logic                     spi1_cycle_i,
    input  logic                     wb_strobe_i,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    input  logic                     cfg_we_i,
    input  logic [SLOT_BITS-1:0]     cfg_slot_i,
    input  logic [1:0]               cfg_owner_i,
    output logic                     wbc_sel_o,
    output logic                     wb_en_o,
    output logic                     cpu_grant_en_o,
    output logic [SLOT_BITS-1:0]     slot_o,
    output logic                     overrun_o,
    output logic [OVR_CNT_WIDTH-1:0] overrun_count_o
);

    logic [SLOT_BITS-1:0]     slot_q;
    logic [SLOT_BITS-1:0]     slot_next;
    logic [1:0]               owner_raw;
    owner_t                   owner_next;
    logic                     busy_q;
    logic                     busy_hold;
    logic                     eff_valid;
    logic                     eff_spi;
    logic                     wbc_sel_q;
    logic                     wb_en_q;
    logic                     cpu_grant_q;
    logic                     overrun_q;
    logic [OVR_CNT_WIDTH-1:0] overrun_cnt_q;

    assign slot_next  = slot_q + 1'b1;
    assign owner_next = owner_t'(owner_raw);

    wb_slot_scheduler_slot_table #(
        .SLOT_BITS (SLOT_BITS)
    ) u_slot_table (
        .clk_sys  (wb_clock_i),
        .rst_b    (wb_reset_ni),
        .we       (cfg_we_i),
        .wr_slot  (cfg_slot_i),
        .wr_owner (cfg_owner_i),
        .rd_slot  (slot_next),
        .rd_owner (owner_raw)
    );

    // An ack arriving on the decide edge retires the transfer before the slot is judged.
    assign busy_hold = busy_q & ~wb_ack_i;

    always_comb begin
        eff_valid = 1'b0;
        eff_spi   = 1'b0;
        case (owner_next)
            OWNER_CPU: begin
                eff_valid = 1'b0;
            end
            OWNER_SPI: begin
                if (spi1_cycle_i) begin
                    eff_valid = 1'b1;
                    eff_spi   = 1'b1;
                end else if (video_cycle_i) begin
                    eff_valid = 1'b1;
                end
            end
            default: begin
                if (video_cycle_i) begin
                    eff_valid = 1'b1;
                end else if (spi1_cycle_i) begin
                    eff_valid = 1'b1;
                    eff_spi   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            slot_q        <= '1;
            wbc_sel_q     <= 1'b0;
            wb_en_q       <= 1'b0;
            cpu_grant_q   <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            wb_en_q     <= 1'b0;
            cpu_grant_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (clk8_en_i) begin
                slot_q <= slot_next;
                if (busy_hold) begin
                    overrun_q <= 1'b1;
                    if (overrun_cnt_q != '1) begin
                        overrun_cnt_q <= overrun_cnt_q + 1'b1;
                    end
                end else if (owner_next == OWNER_CPU) begin
                    cpu_grant_q <= 1'b1;
                end else if (eff_valid) begin
                    wb_en_q   <= 1'b1;
                    wbc_sel_q <= eff_spi;
                end
            end
            if (wb_ack_i) begin
                busy_q <= 1'b0;
            end else if (wb_strobe_i && !wb_stall_i) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign wbc_sel_o       = wbc_sel_q;
    assign wb_en_o         = wb_en_q;
    assign cpu_grant_en_o  = cpu_grant_q;
    assign slot_o          = slot_q;
    assign overrun_o       = overrun_q;
    assign overrun_count_o = overrun_cnt_q;

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Scoreboard bench: a slot-level reference model queues expected pulses, a monitor retires them.
module tb_wb_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk8_en = 1'b0;
    logic       video = 1'b0;
    logic       spi = 1'b0;
    logic       strobe = 1'b0;
    logic       stall = 1'b0;
    logic       ack = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_slot = 3'd0;
    logic [1:0] cfg_owner = 2'd0;

    logic       wbc_sel;
    logic       wb_en;
    logic       cpu_grant;
    logic [2:0] slot;
    logic       overrun;
    logic [7:0] overrun_count;

    wb_slot_scheduler #(.SLOT_BITS(3), .OVR_CNT_WIDTH(8)) dut (
        .wb_clock_i      (clk),
        .wb_reset_ni     (rst_n),
        .clk8_en_i       (clk8_en),
        .video_cycle_i   (video),
        .spi1_cycle_i    (spi),
        .wb_strobe_i     (strobe),
        .wb_stall_i      (stall),
        .wb_ack_i        (ack),
        .cfg_we_i        (cfg_we),
        .cfg_slot_i      (cfg_slot),
        .cfg_owner_i     (cfg_owner),
        .wbc_sel_o       (wbc_sel),
        .wb_en_o         (wb_en),
        .cpu_grant_en_o  (cpu_grant),
        .slot_o          (slot),
        .overrun_o       (overrun),
        .overrun_count_o (overrun_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Owner encoding: 0 idle, 1 video, 2 cpu, 3 spi.
    typedef struct {
        int cyc;
        bit en;
        bit cpu;
        bit ovr;
        bit sel;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   m_slot = 7;
    int   m_table[8] = '{1, 1, 1, 1, 2, 2, 3, 3};
    bit   m_busy = 0;
    bit   m_sel = 0;
    int   m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        int ns;
        int own;
        int pick;
        if (!rst_n) begin
            m_slot  = 7;
            m_table = '{1, 1, 1, 1, 2, 2, 3, 3};
            m_busy  = 0;
            m_sel   = 0;
            m_cnt   = 0;
            q.delete();
        end else begin
            edge_n++;
            if (clk8_en) begin
                ns  = (m_slot + 1) % 8;
                own = m_table[ns];
                if (m_busy && !ack) begin
                    q.push_back('{edge_n, 1'b0, 1'b0, 1'b1, m_sel});
                    if (m_cnt < 255) m_cnt++;
                end else if (own == 2) begin
                    q.push_back('{edge_n, 1'b0, 1'b1, 1'b0, m_sel});
                end else begin
                    if (own == 3) pick = spi ? 1 : (video ? 0 : -1);
                    else          pick = video ? 0 : (spi ? 1 : -1);
                    if (pick >= 0) begin
                        m_sel = (pick == 1);
                        q.push_back('{edge_n, 1'b1, 1'b0, 1'b0, m_sel});
                    end
                end
                m_slot = ns;
            end
            if (ack) m_busy = 0;
            else if (strobe && !stall) m_busy = 1;
            if (cfg_we) m_table[cfg_slot] = int'(cfg_owner);
        end
    end

    int n_cpu = 0;
    int n_vid = 0;
    int n_spi = 0;

    always @(negedge clk) begin
        exp_t e;
        chk("slot", int'(slot), m_slot);
        chk("overrun_count", int'(overrun_count), m_cnt);
        chk("wbc_sel", int'(wbc_sel), int'(m_sel));
        chk("en_cpu_exclusive", int'(wb_en & cpu_grant), 0);
        if (cpu_grant) n_cpu++;
        if (wb_en && wbc_sel) n_spi++;
        if (wb_en && !wbc_sel) n_vid++;
        while (q.size() > 0 && q[0].cyc < edge_n) begin
            e = q.pop_front();
            chk("missing_pulse_cycle", edge_n, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == edge_n) begin
            e = q.pop_front();
            chk("wb_en", int'(wb_en), int'(e.en));
            chk("cpu_grant", int'(cpu_grant), int'(e.cpu));
            chk("overrun", int'(overrun), int'(e.ovr));
        end else begin
            chk("unexpected_pulse", int'(wb_en | cpu_grant | overrun), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic adv();
        clk8_en = 1'b1;
        cyc(1);
        clk8_en = 1'b0;
    endtask

    task automatic accept();
        strobe = 1'b1;
        cyc(1);
        strobe = 1'b0;
    endtask

    initial begin
        cyc(3);
        @(negedge clk);
        chk("rst_slot", int'(slot), 7);
        chk("rst_outputs", int'({wbc_sel, wb_en, cpu_grant, overrun}), 0);
        chk("rst_count", int'(overrun_count), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // full pass with both requesters on
        n_cpu = 0; n_vid = 0; n_spi = 0;
        video = 1'b1; spi = 1'b1;
        repeat (8) begin adv(); cyc(3); end
        chk("pass_cpu_grants", n_cpu, 2);
        chk("pass_video_en", n_vid, 4);
        chk("pass_spi_en", n_spi, 2);

        // video slots donated to SPI, then nobody requesting
        video = 1'b0; spi = 1'b1;
        repeat (3) begin adv(); cyc(2); end
        chk("donated_sel", int'(wbc_sel), 1);
        spi = 1'b0;
        n_vid = 0; n_spi = 0;
        adv(); cyc(2);
        chk("idle_no_enable", n_vid + n_spi, 0);

        // overrun: transfer accepted in slot 6, ack withheld past the next advance
        video = 1'b1; spi = 1'b1;
        repeat (3) begin adv(); cyc(2); end
        accept();
        cyc(2);
        adv();
        @(negedge clk);
        chk("overrun_count_first", int'(overrun_count), 1);
        chk("sel_held", int'(wbc_sel), 1);
        cyc(1);
        ack = 1'b1; cyc(1); ack = 1'b0;
        cyc(2);

        // ack on the decide edge: no overrun
        accept();
        cyc(2);
        ack = 1'b1;
        adv();
        ack = 1'b0;
        @(negedge clk);
        chk("ack_on_decide_grant", int'(wb_en), 1);
        chk("ack_on_decide_count", int'(overrun_count), 1);
        cyc(2);

        // reprogram slot 4 while in it; slot 5 write lands on its own advance edge
        repeat (4) begin adv(); cyc(2); end
        cfg_we = 1'b1; cfg_slot = 3'd4; cfg_owner = 2'd3;
        cyc(1);
        cfg_slot = 3'd5; cfg_owner = 2'd1;
        adv();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("old_owner_latched", int'(cpu_grant), 1);
        cyc(2);
        n_cpu = 0;
        repeat (8) begin adv(); cyc(2); end
        chk("reprogrammed_no_cpu", n_cpu, 0);

        // saturate the overrun counter, then reset mid-transaction
        accept();
        repeat (300) begin adv(); cyc(1); end
        chk("overrun_saturated", int'(overrun_count), 255);
        accept();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", int'({wbc_sel, wb_en, cpu_grant, overrun}), 0);
        chk("midrst_slot", int'(slot), 7);
        chk("midrst_count", int'(overrun_count), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        adv();
        @(negedge clk);
        chk("post_rst_grant", int'(wb_en), 1);
        cyc(1);

        // randomized traffic
        repeat (3000) begin
            clk8_en   = ($urandom_range(0, 3) == 0);
            video     = $urandom_range(0, 1) == 1;
            spi       = $urandom_range(0, 1) == 1;
            strobe    = ($urandom_range(0, 3) == 0);
            stall     = ($urandom_range(0, 2) == 0);
            ack       = ($urandom_range(0, 4) == 0);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_slot  = 3'($urandom_range(0, 7));
            cfg_owner = 2'($urandom_range(0, 3));
            cyc(1);
        end
        {clk8_en, strobe, ack, cfg_we} = 4'b0;
        cyc(4);
        chk("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
